// File: rtl/delay_meas.sv
// delay_meas: loopback latency meter that flushes a path with zeros, injects a marker word and counts cycles until it returns
module delay_meas #(
  parameter int W = 16,
  parameter int CW = 16,
  parameter logic [W-1:0] MARK = 16'hA5C3,
  parameter int FLUSH_CYC = 64,
  parameter int MAX_WAIT = 1000
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          start,
  output logic [W-1:0]  tx_out,
  input  logic [W-1:0]  rx_in,
  output logic          busy,
  output logic          done,
  output logic          tout,
  output logic [CW-1:0] delay
);
  typedef enum logic [1:0] {IDLE, FLUSH, SEND, WAIT} state_t;
  state_t st;
  logic [CW-1:0] cnt;
  logic hit;
  assign hit = rx_in == MARK;
  // One counter serves both the flush interval and the latency count; a start seen alongside done is dropped so a new run always begins from a quiet IDLE cycle
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      st <= IDLE;
      cnt <= '0;
      tx_out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      tout <= 1'b0;
      delay <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE:
          if (start && !done) begin
            st <= FLUSH;
            busy <= 1'b1;
            tout <= 1'b0;
            cnt <= '0;
          end
        FLUSH:
          if (cnt == CW'(FLUSH_CYC - 1)) begin
            st <= SEND;
            tx_out <= MARK;
            cnt <= '0;
          end else cnt <= cnt + CW'(1);
        SEND: begin
          tx_out <= '0;
          if (hit) begin
            delay <= '0;
            done <= 1'b1;
            busy <= 1'b0;
            st <= IDLE;
          end else begin
            st <= WAIT;
            cnt <= CW'(1);
          end
        end
        WAIT:
          if (hit) begin
            delay <= cnt;
            done <= 1'b1;
            busy <= 1'b0;
            st <= IDLE;
          end else if (cnt == CW'(MAX_WAIT)) begin
            delay <= '1;
            tout <= 1'b1;
            done <= 1'b1;
            busy <= 1'b0;
            st <= IDLE;
          end else cnt <= cnt + CW'(1);
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_delay_meas.sv
// tb_delay_meas: scoreboard bench driving delay_meas through modelled paths of various latencies
module tb_delay_meas;
  localparam logic [15:0] MARK = 16'hA5C3;
  localparam int MAX_WAIT = 1000;
  logic clk = 1'b0, reset_b = 1'b0, start = 1'b0;
  logic [15:0] tx_out, rx_in, delay;
  logic busy, done, tout;
  logic [15:0] pipe [16];
  int mode = 0, d = 1, cyc = 0, mark_cyc = 0, n_chk = 0, n_pass = 0;
  logic done_q = 1'b0;
  typedef struct {logic [31:0] dl; logic [31:0] to; logic [31:0] gap;} exp_t;
  exp_t q[$];
  delay_meas #(.W(16), .CW(16), .MARK(MARK), .FLUSH_CYC(64), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset_b(reset_b), .start(start), .tx_out(tx_out), .rx_in(rx_in),
    .busy(busy), .done(done), .tout(tout), .delay(delay)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // path under test: a register delay line sharing the meter's reset
  always @(posedge clk or negedge reset_b)
    if (!reset_b) for (int i = 0; i < 16; i++) pipe[i] <= '0;
    else begin
      pipe[0] <= tx_out;
      for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    end
  always_comb rx_in = mode == 0 ? tx_out : mode == 1 ? pipe[d-1] : mode == 2 ? 16'h0 : MARK;
  function automatic void chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endfunction
  // scoreboard: every done pops one expected result
  always @(negedge clk) begin
    exp_t e;
    if (tx_out == MARK) mark_cyc = cyc;
    if (done_q) chk("done_1cyc", 32'(done), 32'd0);
    if (done) begin
      chk("sb_has_entry", 32'(q.size()), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("delay", 32'(delay), e.dl);
        chk("tout", 32'(tout), e.to);
        chk("done_gap", 32'(cyc - mark_cyc), e.gap);
        chk("busy_off", 32'(busy), 32'd0);
      end
    end
    done_q = done;
  end
  task automatic measure(input logic [15:0] ed, input bit et, input int gap, input int poke, input int sw, input bit sod);
    bit seen;
    q.push_back('{32'(ed), 32'(et), 32'(gap)});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on", 32'(busy), 32'd1);
    chk("tout_clr", 32'(tout), 32'd0);
    seen = 1'b0;
    for (int k = 1; k < 3000 && !seen; k++) begin
      if (k == poke) start = 1'b1;
      if (k == sw) mode = 1;
      @(negedge clk);
      start = 1'b0;
      if (k == poke) chk("busy_poke", 32'(busy), 32'd1);
      seen = done;
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen && sod) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_on_done_ignored", 32'(busy), 32'd0);
    end
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tout", 32'(tout), 32'd0);
    chk("rst_delay", 32'(delay), 32'd0);
    reset_b = 1'b1;
    @(negedge clk);
    mode = 0;
    measure(16'd0, 1'b0, 1, 0, 0, 1'b1);
    mode = 1; d = 10;
    measure(16'd10, 1'b0, 11, 0, 0, 1'b0);
    d = 2;
    measure(16'd2, 1'b0, 3, 20, 0, 1'b0);
    d = 1;
    measure(16'd1, 1'b0, 2, 0, 0, 1'b0);
    mode = 2;
    measure(16'hFFFF, 1'b1, MAX_WAIT + 1, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("tout_held", 32'(tout), 32'd1);
    chk("delay_held", 32'(delay), 32'hFFFF);
    mode = 3; d = 5;
    measure(16'd5, 1'b0, 6, 0, 10, 1'b0);
    mode = 1; d = 10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (67) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 reset_b = 1'b0;
    #1;
    chk("arst_tx", 32'(tx_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    measure(16'd10, 1'b0, 11, 0, 0, 1'b0);
    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
